// File: rtl/mem_bus_arbiter.sv
// Arbitrates a single registered req/ack memory bus between fetch and the memory stage,
// with alternating priority under contention and a timeout abort for hung bus cycles.
module mem_bus_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ack_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ack_o,
    output logic        bus_cyc_o,
    output logic        bus_stb_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        bus_err_o,
    output logic        stallreq_o
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] IF_BUSY  = 2'd1;
    localparam logic [1:0] MEM_BUSY = 2'd2;

    logic [1:0] state;
    logic [7:0] cnt;
    logic       alt_if;
    logic       if_pend, mem_pend, grant_if, grant_mem, timeout_hit;

    // A requester still sees its own ack this cycle; masking avoids regranting a finished request.
    assign if_pend     = if_req_i & ~if_ack_o;
    assign mem_pend    = mem_req_i & ~mem_ack_o;
    assign grant_if    = (state == IDLE) & if_pend & (~mem_pend | alt_if);
    assign grant_mem   = (state == IDLE) & mem_pend & ~grant_if;
    assign timeout_hit = (state != IDLE) & ~bus_ack_i & (cnt == 8'(TIMEOUT - 1));
    assign bus_stb_o   = bus_cyc_o;
    assign stallreq_o  = rst & (if_pend | mem_pend);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            alt_if      <= 1'b0;
            bus_cyc_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= '0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            bus_err_o   <= 1'b0;
            if_rdata_o  <= '0;
            if_ack_o    <= 1'b0;
            mem_rdata_o <= '0;
            mem_ack_o   <= 1'b0;
        end else begin
            if_ack_o  <= 1'b0;
            mem_ack_o <= 1'b0;
            bus_err_o <= 1'b0;
            if (state == IDLE) begin
                if (grant_mem) begin
                    state       <= MEM_BUSY;
                    cnt         <= '0;
                    alt_if      <= if_pend;
                    bus_cyc_o   <= 1'b1;
                    bus_we_o    <= mem_we_i;
                    bus_sel_o   <= mem_sel_i;
                    bus_addr_o  <= mem_addr_i;
                    bus_wdata_o <= mem_wdata_i;
                end else if (grant_if) begin
                    state       <= IF_BUSY;
                    cnt         <= '0;
                    alt_if      <= 1'b0;
                    bus_cyc_o   <= 1'b1;
                    bus_we_o    <= 1'b0;
                    bus_sel_o   <= 4'b1111;
                    bus_addr_o  <= if_addr_i;
                    bus_wdata_o <= '0;
                end
            end else if (bus_ack_i) begin
                state     <= IDLE;
                bus_cyc_o <= 1'b0;
                if (state == IF_BUSY) begin
                    if_ack_o   <= 1'b1;
                    if_rdata_o <= bus_rdata_i;
                end else begin
                    mem_ack_o <= 1'b1;
                    if (!bus_we_o) mem_rdata_o <= bus_rdata_i;
                end
            end else if (timeout_hit) begin
                state     <= IDLE;
                bus_cyc_o <= 1'b0;
                bus_err_o <= 1'b1;
                if (state == IF_BUSY) begin
                    if_ack_o   <= 1'b1;
                    if_rdata_o <= '0;
                end else begin
                    mem_ack_o   <= 1'b1;
                    mem_rdata_o <= '0;
                end
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fetch, waited store, contention, timeout, async reset, stale ack.
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i, mem_req_i, mem_we_i, bus_ack_i;
    logic [31:0] if_addr_i, mem_addr_i, mem_wdata_i, bus_rdata_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] if_rdata_o, mem_rdata_o, bus_addr_o, bus_wdata_o;
    logic        if_ack_o, mem_ack_o, bus_cyc_o, bus_stb_o, bus_we_o, bus_err_o, stallreq_o;
    logic [3:0]  bus_sel_o;
    int          n_cmp = 0;
    int          n_err = 0;

    mem_bus_arbiter #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o),
        .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
        .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o), .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; sample point is 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        {if_req_i, mem_req_i, mem_we_i, bus_ack_i} = '0;
        {if_addr_i, mem_addr_i, mem_wdata_i, bus_rdata_i} = '0;
        mem_sel_i = '0;
        step();
        chk("rst_bus", {31'd0, bus_stb_o} | {31'd0, bus_cyc_o} | bus_addr_o, 32'h0);
        chk("rst_acks", {28'd0, if_ack_o, mem_ack_o, bus_err_o, stallreq_o}, 32'h0);
        chk("rst_rdata", if_rdata_o | mem_rdata_o, 32'h0);
        step();
        rst = 1'b1;

        // Zero-wait fetch: request in cycle 0, stb in cycle 1, ack_o in cycle 2.
        if_req_i = 1'b1; if_addr_i = 32'h0000_0100;
        step();
        chk("f_stb", {27'd0, bus_stb_o, bus_we_o, bus_sel_o}, {27'd0, 1'b1, 1'b0, 4'hF});
        chk("f_addr", bus_addr_o, 32'h0000_0100);
        chk("f_stall", {31'd0, stallreq_o}, 32'd1);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h2402_0005;
        step();
        chk("f_ack", {30'd0, if_ack_o, bus_stb_o}, 32'b10);
        chk("f_rdata", if_rdata_o, 32'h2402_0005);
        chk("f_stall_end", {31'd0, stallreq_o}, 32'd0);
        if_req_i = 1'b0; bus_ack_i = 1'b0;
        step();
        chk("f_ack_1cyc", {31'd0, if_ack_o}, 32'd0);
        chk("f_rdata_hold", if_rdata_o, 32'h2402_0005);

        // Store with four wait cycles: outputs frozen across all five stb cycles.
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b0011;
        mem_addr_i = 32'h0000_0200; mem_wdata_i = 32'hDEAD_BEEF;
        step();
        mem_addr_i = 32'h1111_1111; mem_wdata_i = 32'h0; mem_sel_i = 4'hF;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("s_ctl%0d", i), {26'd0, bus_stb_o, bus_we_o, bus_sel_o, stallreq_o, mem_ack_o},
                {26'd0, 1'b1, 1'b1, 4'b0011, 1'b1, 1'b0});
            chk($sformatf("s_addr%0d", i), bus_addr_o, 32'h0000_0200);
            chk($sformatf("s_wdata%0d", i), bus_wdata_o, 32'hDEAD_BEEF);
            if (i == 4) begin bus_ack_i = 1'b1; bus_rdata_i = 32'h5555_5555; end
            step();
        end
        chk("s_ack", {29'd0, mem_ack_o, bus_stb_o, stallreq_o}, 32'b100);
        chk("s_rdata_keep", mem_rdata_o, 32'h0);
        mem_req_i = 1'b0; mem_we_i = 1'b0; bus_ack_i = 1'b0;
        step();
        chk("s_ack_1cyc", {31'd0, mem_ack_o}, 32'd0);

        // Contention: MEM first, then IF, then a fresh MEM request.
        mem_req_i = 1'b1; mem_addr_i = 32'h0000_0300; mem_sel_i = 4'hF;
        if_req_i = 1'b1; if_addr_i = 32'h0000_0104;
        step();
        chk("c_g1", bus_addr_o, 32'h0000_0300);
        bus_ack_i = 1'b1; bus_rdata_i = 32'hAAAA_0001;
        step();
        chk("c_ack1", {30'd0, mem_ack_o, if_ack_o}, 32'b10);
        chk("c_rd1", mem_rdata_o, 32'hAAAA_0001);
        mem_addr_i = 32'h0000_0304; bus_ack_i = 1'b0;
        step();
        chk("c_g2", bus_addr_o, 32'h0000_0104);
        chk("c_g2_sel", {28'd0, bus_sel_o}, 32'hF);
        bus_ack_i = 1'b1; bus_rdata_i = 32'hBBBB_0002;
        step();
        chk("c_ack2", {30'd0, mem_ack_o, if_ack_o}, 32'b01);
        chk("c_rd2", if_rdata_o, 32'hBBBB_0002);
        if_req_i = 1'b0; bus_ack_i = 1'b0;
        step();
        chk("c_g3", bus_addr_o, 32'h0000_0304);
        bus_ack_i = 1'b1; bus_rdata_i = 32'hCCCC_0003;
        step();
        chk("c_rd3", {31'd0, mem_ack_o}, 32'd1);
        chk("c_rd3_val", mem_rdata_o, 32'hCCCC_0003);
        mem_req_i = 1'b0; bus_ack_i = 1'b0;
        step();

        // Timeout: load never acked, abort after 8 busy cycles.
        mem_req_i = 1'b1; mem_addr_i = 32'h0000_0400;
        step();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t_busy%0d", i), {29'd0, bus_stb_o, bus_err_o, mem_ack_o}, 32'b100);
            step();
        end
        chk("t_abort", {29'd0, bus_stb_o, bus_err_o, mem_ack_o}, 32'b011);
        chk("t_rdata", mem_rdata_o, 32'h0);
        mem_req_i = 1'b0;
        step();
        chk("t_err_1cyc", {30'd0, bus_err_o, mem_ack_o}, 32'd0);

        // Async reset mid-transaction.
        mem_req_i = 1'b1; mem_addr_i = 32'h0000_0500;
        step();
        chk("r_busy", {31'd0, bus_stb_o}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("r_bus", {30'd0, bus_stb_o, bus_cyc_o} | bus_addr_o, 32'h0);
        chk("r_flags", {28'd0, mem_ack_o, if_ack_o, bus_err_o, stallreq_o}, 32'h0);
        chk("r_rdata", if_rdata_o, 32'h0);
        mem_req_i = 1'b0;
        step();
        chk("r_noack", {30'd0, mem_ack_o, bus_err_o}, 32'h0);
        rst = 1'b1;
        if_req_i = 1'b1; if_addr_i = 32'h0000_0108;
        step();
        chk("r_fetch_addr", bus_addr_o, 32'h0000_0108);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h1111_2222;
        step();
        chk("r_fetch_ack", {31'd0, if_ack_o}, 32'd1);
        chk("r_fetch_rd", if_rdata_o, 32'h1111_2222);
        if_req_i = 1'b0; bus_ack_i = 1'b0;
        step();

        // Stale ack in IDLE is ignored.
        bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
        step();
        chk("x_acks", {29'd0, if_ack_o, mem_ack_o, bus_stb_o}, 32'h0);
        chk("x_if_rd", if_rdata_o, 32'h1111_2222);
        chk("x_mem_rd", mem_rdata_o, 32'h0);
        bus_ack_i = 1'b0;
        mem_req_i = 1'b1; mem_addr_i = 32'h0000_0600;
        step();
        chk("x_idle_grant", bus_addr_o, 32'h0000_0600);
        mem_req_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'h0;
        step();
        bus_ack_i = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
